// File: rtl/alu_port_if.sv
// Request/response channel bundle for one requester port of alu_arbiter.
// The requester side uses the master modport and the arbiter uses the slave modport.
interface alu_port_if;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic [3:0] req_oper;
  logic       resp_valid;
  logic       resp_ready;
  logic [7:0] resp_r;
  logic       resp_zero;
  logic       resp_err;

  modport master (
    output req_valid, req_a, req_b, req_oper, resp_ready,
    input  req_ready, resp_valid, resp_r, resp_zero, resp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_oper, resp_ready,
    output req_ready, resp_valid, resp_r, resp_zero, resp_err
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one 8-bit combinational ALU between two requesters,
// sequenced IDLE -> EXEC -> RESP with registered responses.

module alu8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [3:0] oper,
  output logic [7:0] r,
  output logic       illegal
);
  // Combinational ALU; shift amounts of 8 or more flush the operand.
  always_comb begin
    r       = 8'h00;
    illegal = 1'b0;
    case (oper)
      4'b0000: r = a + b;
      4'b0001: r = a - b;
      4'b0010: r = a & b;
      4'b0011: r = a | b;
      4'b0100: r = a ^ b;
      4'b0101: r = (b >= 8'd8) ? 8'h00 : (a << b[2:0]);
      4'b0110: r = (b >= 8'd8) ? 8'h00 : (a >> b[2:0]);
      default: begin
        r       = 8'h00;
        illegal = 1'b1;
      end
    endcase
  end
endmodule

module alu_arbiter #(
  parameter logic RR_INIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  alu_port_if.slave  p0,
  alu_port_if.slave  p1,
  output logic       busy
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state_r;
  logic       prio_r;
  logic       gnt_r;
  logic [7:0] a_r;
  logic [7:0] b_r;
  logic [3:0] oper_r;
  logic       busy_r;
  logic       resp0_valid_r, resp0_zero_r, resp0_err_r;
  logic       resp1_valid_r, resp1_zero_r, resp1_err_r;
  logic [7:0] resp0_r_r, resp1_r_r;

  logic       gnt_s;
  logic       accept_s;
  logic       resp_done_s;
  logic [7:0] alu_r_s;
  logic       alu_illegal_s;
  logic [7:0] res_r_s;
  logic       res_zero_s;

  alu8 u_alu (
    .a       (a_r),
    .b       (b_r),
    .oper    (oper_r),
    .r       (alu_r_s),
    .illegal (alu_illegal_s)
  );

  // Grant selection and handshake qualification; ready is suppressed during reset.
  always_comb begin
    gnt_s = 1'b0;
    if (p0.req_valid && p1.req_valid) begin
      gnt_s = prio_r;
    end else if (p1.req_valid) begin
      gnt_s = 1'b1;
    end else begin
      gnt_s = 1'b0;
    end
    accept_s    = (state_r == IDLE) && !rst && (p0.req_valid || p1.req_valid);
    resp_done_s = (state_r == RESP) && (gnt_r ? p1.resp_ready : p0.resp_ready);
  end

  // Illegal opcodes override whatever the ALU produced.
  always_comb begin
    res_r_s    = 8'h00;
    res_zero_s = 1'b1;
    if (alu_illegal_s) begin
      res_r_s    = 8'h00;
      res_zero_s = 1'b1;
    end else begin
      res_r_s    = alu_r_s;
      res_zero_s = (alu_r_s == 8'h00);
    end
  end

  // Sequencing FSM with registered response outputs and round-robin priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      prio_r        <= RR_INIT;
      gnt_r         <= 1'b0;
      a_r           <= 8'h00;
      b_r           <= 8'h00;
      oper_r        <= 4'h0;
      busy_r        <= 1'b0;
      resp0_valid_r <= 1'b0;
      resp0_r_r     <= 8'h00;
      resp0_zero_r  <= 1'b0;
      resp0_err_r   <= 1'b0;
      resp1_valid_r <= 1'b0;
      resp1_r_r     <= 8'h00;
      resp1_zero_r  <= 1'b0;
      resp1_err_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            gnt_r   <= gnt_s;
            a_r     <= gnt_s ? p1.req_a    : p0.req_a;
            b_r     <= gnt_s ? p1.req_b    : p0.req_b;
            oper_r  <= gnt_s ? p1.req_oper : p0.req_oper;
            busy_r  <= 1'b1;
            state_r <= EXEC;
          end
        end
        EXEC: begin
          if (gnt_r) begin
            resp1_valid_r <= 1'b1;
            resp1_r_r     <= res_r_s;
            resp1_zero_r  <= res_zero_s;
            resp1_err_r   <= alu_illegal_s;
          end else begin
            resp0_valid_r <= 1'b1;
            resp0_r_r     <= res_r_s;
            resp0_zero_r  <= res_zero_s;
            resp0_err_r   <= alu_illegal_s;
          end
          state_r <= RESP;
        end
        RESP: begin
          if (resp_done_s) begin
            resp0_valid_r <= 1'b0;
            resp0_r_r     <= 8'h00;
            resp0_zero_r  <= 1'b0;
            resp0_err_r   <= 1'b0;
            resp1_valid_r <= 1'b0;
            resp1_r_r     <= 8'h00;
            resp1_zero_r  <= 1'b0;
            resp1_err_r   <= 1'b0;
            prio_r        <= ~gnt_r;
            busy_r        <= 1'b0;
            state_r       <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign p0.req_ready  = accept_s && !gnt_s;
  assign p1.req_ready  = accept_s && gnt_s;
  assign p0.resp_valid = resp0_valid_r;
  assign p0.resp_r     = resp0_r_r;
  assign p0.resp_zero  = resp0_zero_r;
  assign p0.resp_err   = resp0_err_r;
  assign p1.resp_valid = resp1_valid_r;
  assign p1.resp_r     = resp1_r_r;
  assign p1.resp_zero  = resp1_zero_r;
  assign p1.resp_err   = resp1_err_r;
  assign busy          = busy_r;
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed requests push expected responses,
// per-port monitors pop and compare whenever a response handshake occurs.
module tb_alu_arbiter;
  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_SHL = 4'b0101;
  localparam logic [3:0] OP_SHR = 4'b0110;
  localparam logic [3:0] OP_BAD = 4'b1010;

  typedef struct packed {
    logic [7:0] r;
    logic       z;
    logic       e;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   tests = 0;
  int   fails = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t m0_e;
  exp_t m1_e;

  alu_port_if p0 ();
  alu_port_if p1 ();

  alu_arbiter #(.RR_INIT(1'b0)) dut (
    .clk  (clk),
    .rst  (rst),
    .p0   (p0),
    .p1   (p1),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Response monitors, sampled on the falling edge ahead of the handshake edge.
  always @(negedge clk) begin
    if (!rst && p0.resp_valid && p0.resp_ready) begin
      if (q0.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL resp0_unexpected: got r=%0h, expected no response", p0.resp_r);
      end else begin
        m0_e = q0.pop_front();
        check("resp0_r", p0.resp_r, m0_e.r);
        check("resp0_zero", p0.resp_zero, m0_e.z);
        check("resp0_err", p0.resp_err, m0_e.e);
        check("resp1_quiet", {p1.resp_valid, p1.resp_r, p1.resp_zero, p1.resp_err}, 0);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && p1.resp_valid && p1.resp_ready) begin
      if (q1.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL resp1_unexpected: got r=%0h, expected no response", p1.resp_r);
      end else begin
        m1_e = q1.pop_front();
        check("resp1_r", p1.resp_r, m1_e.r);
        check("resp1_zero", p1.resp_zero, m1_e.z);
        check("resp1_err", p1.resp_err, m1_e.e);
        check("resp0_quiet", {p0.resp_valid, p0.resp_r, p0.resp_zero, p0.resp_err}, 0);
      end
    end
  end

  task automatic push_exp(input int port, input logic [7:0] r, input logic z, input logic e);
    exp_t x;
    x.r = r;
    x.z = z;
    x.e = e;
    if (port == 0) q0.push_back(x);
    else q1.push_back(x);
  endtask

  task automatic set_req(input int port, input logic v, input logic [7:0] a,
                         input logic [7:0] b, input logic [3:0] op);
    if (port == 0) begin
      p0.req_valid = v; p0.req_a = a; p0.req_b = b; p0.req_oper = op;
    end else begin
      p1.req_valid = v; p1.req_a = a; p1.req_b = b; p1.req_oper = op;
    end
  endtask

  function automatic logic get_ready(input int port);
    return (port == 0) ? p0.req_ready : p1.req_ready;
  endfunction

  function automatic logic get_rvalid(input int port);
    return (port == 0) ? p0.resp_valid : p1.resp_valid;
  endfunction

  task automatic accept(input int port, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] op, input logic [7:0] er, input logic ez,
                        input logic ee, input bit push);
    int n;
    n = 0;
    @(posedge clk); #1;
    set_req(port, 1'b1, a, b, op);
    @(negedge clk);
    while (!get_ready(port) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", get_ready(port), 1);
    if (push) push_exp(port, er, ez, ee);
    @(posedge clk); #1;
    set_req(port, 1'b0, 8'h00, 8'h00, 4'h0);
  endtask

  task automatic do_op(input int port, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] op, input logic [7:0] er, input logic ez,
                       input logic ee);
    accept(port, a, b, op, er, ez, ee, 1'b1);
    @(negedge clk);
    check("lat_t1_valid", get_rvalid(port), 0);
    check("lat_t1_busy", busy, 1);
    @(negedge clk);
    check("lat_t2_valid", get_rvalid(port), 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || p0.resp_valid || p1.resp_valid) && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", (n < 30), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_resp0"}, {p0.resp_valid, p0.resp_r, p0.resp_zero, p0.resp_err}, 0);
    check({tag, "_resp1"}, {p1.resp_valid, p1.resp_r, p1.resp_zero, p1.resp_err}, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Both ports request together; priority at RR_INIT=0 must grant port 0.
  task automatic check_prio_init(input string tag);
    @(posedge clk); #1;
    set_req(0, 1'b1, 8'h11, 8'h22, OP_ADD);
    set_req(1, 1'b1, 8'h11, 8'h22, OP_SUB);
    @(negedge clk);
    check({tag, "_ready0"}, p0.req_ready, 1);
    check({tag, "_ready1"}, p1.req_ready, 0);
    push_exp(0, 8'h33, 1'b0, 1'b0);
    @(posedge clk); #1;
    set_req(0, 1'b0, 8'h00, 8'h00, 4'h0);
    set_req(1, 1'b0, 8'h00, 8'h00, 4'h0);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int   grants;
    int   order[4];
    int   n;
    logic [7:0] held_r;

    rst = 1'b1;
    set_req(0, 1'b1, 8'h00, 8'h00, 4'h0);
    set_req(1, 1'b1, 8'h00, 8'h00, 4'h0);
    p0.resp_ready = 1'b1;
    p1.resp_ready = 1'b1;
    @(negedge clk);
    check("rst_ready0", p0.req_ready, 0);
    check("rst_ready1", p1.req_ready, 0);
    @(posedge clk); #1;
    set_req(0, 1'b0, 8'h00, 8'h00, 4'h0);
    set_req(1, 1'b0, 8'h00, 8'h00, 4'h0);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    do_op(0, 8'h7F, 8'h01, OP_ADD, 8'h80, 1'b0, 1'b0);
    do_op(0, 8'hFF, 8'h01, OP_ADD, 8'h00, 1'b1, 1'b0);
    do_op(0, 8'h00, 8'h01, OP_SUB, 8'hFF, 1'b0, 1'b0);
    do_op(0, 8'h01, 8'h07, OP_SHL, 8'h80, 1'b0, 1'b0);
    do_op(0, 8'h80, 8'h09, OP_SHR, 8'h00, 1'b1, 1'b0);
    wait_idle();

    apply_reset();
    grants = 0;
    n = 0;
    set_req(0, 1'b1, 8'hF0, 8'h0F, OP_XOR);
    set_req(1, 1'b1, 8'hF0, 8'h0F, OP_AND);
    while (grants < 4 && n < 60) begin
      @(negedge clk);
      n++;
      check("rr_exclusive", {p0.req_ready, p1.req_ready} == 2'b11, 0);
      if (p0.req_ready) begin
        order[grants] = 0;
        grants++;
        push_exp(0, 8'hFF, 1'b0, 1'b0);
      end else if (p1.req_ready) begin
        order[grants] = 1;
        grants++;
        push_exp(1, 8'h00, 1'b1, 1'b0);
      end
    end
    @(posedge clk); #1;
    set_req(0, 1'b0, 8'h00, 8'h00, 4'h0);
    set_req(1, 1'b0, 8'h00, 8'h00, 4'h0);
    check("rr_grant_count", grants, 4);
    for (int i = 0; i < 4; i++) check("rr_order", order[i], i % 2);
    wait_idle();

    do_op(1, 8'h12, 8'h34, OP_BAD, 8'h00, 1'b1, 1'b1);
    do_op(1, 8'h03, 8'h04, OP_ADD, 8'h07, 1'b0, 1'b0);
    wait_idle();

    p0.resp_ready = 1'b0;
    accept(0, 8'h0F, 8'h01, OP_SUB, 8'h0E, 1'b0, 1'b0, 1'b1);
    set_req(1, 1'b1, 8'h05, 8'h06, OP_OR);
    n = 0;
    @(negedge clk);
    while (!p0.resp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("bp_resp_seen", p0.resp_valid, 1);
    held_r = p0.resp_r;
    check("bp_held_r", held_r, 8'h0E);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid_hold", p0.resp_valid, 1);
      check("bp_data_hold", {p0.resp_r, p0.resp_zero, p0.resp_err}, {8'h0E, 1'b0, 1'b0});
      check("bp_req1_blocked", p1.req_ready, 0);
      check("bp_busy", busy, 1);
    end
    @(posedge clk); #1;
    p0.resp_ready = 1'b1;
    @(negedge clk);
    check("bp_req1_hs_cycle", p1.req_ready, 0);
    push_exp(1, 8'h07, 1'b0, 1'b0);
    @(negedge clk);
    check("bp_req1_granted", p1.req_ready, 1);
    @(posedge clk); #1;
    set_req(1, 1'b0, 8'h00, 8'h00, 4'h0);
    wait_idle();

    do_op(0, 8'h01, 8'h01, OP_AND, 8'h01, 1'b0, 1'b0);
    wait_idle();
    accept(0, 8'h44, 8'h11, OP_ADD, 8'h55, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_exec");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_exec_no_resp", p0.resp_valid, 0);
    end
    check_prio_init("rst_exec_prio");

    accept(0, 8'h44, 8'h11, OP_ADD, 8'h55, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_resp_inflight", p0.resp_valid, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_resp");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_resp_no_resp", p0.resp_valid, 0);
    end
    check_prio_init("rst_resp_prio");

    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
